// File: rtl/load_store_unit.sv
// RV32I load/store front end: validates and formats one op, holds it on the arbiter port, returns extended load data.
// Accept -> bus request next cycle; response the cycle after the result pulse; stalls on load_store_ready and resp_ready.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_store_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic [1:0]            resp_error,
    output logic                  load_store_valid,
    input  logic                  load_store_ready,
    output logic [ADDR_WIDTH-1:0] load_store_addr,
    output logic                  load_store_is_write,
    output logic [3:0]            store_strobe,
    output logic [DATA_WIDTH-1:0] store_data,
    input  logic                  load_store_result_valid,
    output logic                  load_store_result_ready,
    input  logic [DATA_WIDTH-1:0] load_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic            accept;
    logic            illegal;
    logic            misaligned;
    logic [1:0]      off;
    logic [3:0]      strobe_fmt;
    logic [DATA_WIDTH-1:0] data_fmt;
    logic [DATA_WIDTH-1:0] load_fmt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign req_ready               = (state == IDLE);
    assign load_store_valid        = (state == REQ);
    assign resp_valid              = (state == RESP);
    assign load_store_result_ready = 1'b1;
    assign accept                  = req_valid && req_ready;
    assign off                     = req_addr[1:0];

    always_comb begin
        if (req_is_store)
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
    end

    // Store lane formatting; only meaningful for legal, aligned ops.
    always_comb begin
        strobe_fmt = 4'b1111;
        data_fmt   = req_store_data;
        case (req_funct3[1:0])
            2'b00: begin
                strobe_fmt = 4'b0001 << off;
                data_fmt   = {4{req_store_data[7:0]}};
            end
            2'b01: begin
                strobe_fmt = 4'b0011 << off;
                data_fmt   = {2{req_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = load_data[7:0];
        case (off_q)
            2'b01:   byte_sel = load_data[15:8];
            2'b10:   byte_sel = load_data[23:16];
            2'b11:   byte_sel = load_data[31:24];
            default: ;
        endcase
        half_sel = off_q[1] ? load_data[31:16] : load_data[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'b0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'b0, half_sel};
            default: load_fmt = load_data;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (illegal || misaligned) ? RESP : REQ;
            REQ:  if (load_store_ready) state_nxt = WAIT;
            WAIT: if (load_store_result_valid) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are loaded only on accept, so they stay frozen through REQ and WAIT.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            load_store_addr     <= '0;
            load_store_is_write <= 1'b0;
            store_strobe        <= 4'b0;
            store_data          <= '0;
            off_q               <= 2'b0;
            funct3_q            <= 3'b0;
            resp_data           <= '0;
            resp_tag            <= '0;
            resp_error          <= 2'b0;
        end else if (accept) begin
            load_store_addr     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            load_store_is_write <= req_is_store;
            store_strobe        <= strobe_fmt;
            store_data          <= data_fmt;
            off_q               <= off;
            funct3_q            <= req_funct3;
            resp_data           <= '0;
            resp_tag            <= req_tag;
            resp_error          <= illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
        end else if ((state == WAIT) && load_store_result_valid) begin
            resp_data  <= load_store_is_write ? '0 : load_fmt;
            resp_error <= 2'b00;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with an arithmetic reference model and a scripted arbiter.
module tb_load_store_unit;

    logic        CLK;
    logic        RSTn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_store_data;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic [1:0]  resp_error;
    logic        load_store_valid;
    logic        load_store_ready;
    logic [31:0] load_store_addr;
    logic        load_store_is_write;
    logic [3:0]  store_strobe;
    logic [31:0] store_data;
    logic        load_store_result_valid;
    logic        load_store_result_ready;
    logic [31:0] load_data;

    int checks;
    int failures;

    load_store_unit dut (
        .CLK                     (CLK),
        .RSTn                    (RSTn),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_addr                (req_addr),
        .req_is_store            (req_is_store),
        .req_funct3              (req_funct3),
        .req_store_data          (req_store_data),
        .req_tag                 (req_tag),
        .resp_valid              (resp_valid),
        .resp_ready              (resp_ready),
        .resp_data               (resp_data),
        .resp_tag                (resp_tag),
        .resp_error              (resp_error),
        .load_store_valid        (load_store_valid),
        .load_store_ready        (load_store_ready),
        .load_store_addr         (load_store_addr),
        .load_store_is_write     (load_store_is_write),
        .store_strobe            (store_strobe),
        .store_data              (store_data),
        .load_store_result_valid (load_store_result_valid),
        .load_store_result_ready (load_store_result_ready),
        .load_data               (load_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: derive the whole transaction outcome from the ISA rules.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic [1:0] err, output logic [3:0] strb,
                                  output logic [31:0] sdat, output logic [31:0] rdat);
        bit legal;
        int nb;
        int off;
        longint unsigned mask;
        longint unsigned v;
        longint unsigned acc;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off  = int'(addr % 4);
        err  = 2'b00;
        strb = 4'b0;
        sdat = 32'h0;
        rdat = 32'h0;
        if (!legal) begin
            err = 2'b10;
            return;
        end
        nb   = 1 << f3[1:0];
        mask = (64'd1 << (8 * nb)) - 1;
        if ((addr % nb) != 0) begin
            err = 2'b01;
            return;
        end
        strb = 4'(((1 << nb) - 1) << off);
        acc  = 0;
        for (int i = 0; i < 4 / nb; i++)
            acc = acc | ((64'(wd) & mask) << (8 * nb * i));
        sdat = acc[31:0];
        if (!st) begin
            v = (64'(rd) >> (8 * off)) & mask;
            if (!f3[2] && v[8 * nb - 1])
                v = v | ~mask;
            rdat = v[31:0];
        end
    endfunction

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input logic [4:0] tag,
                         input int lsd, input int rsd, input int rrd);
        logic [1:0]  err;
        logic [3:0]  strb;
        logic [31:0] sdat;
        logic [31:0] rdat;
        model(st, f3, addr, wd, rd, err, strb, sdat, rdat);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_addr       = addr;
        req_store_data = wd;
        req_tag        = tag;
        @(negedge CLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (err == 2'b00) begin
            for (int i = 0; i <= lsd; i++) begin
                check("ls_valid_req", 32'(load_store_valid), 32'd1);
                check("ls_addr", load_store_addr, addr & 32'hFFFF_FFFC);
                check("ls_is_write", 32'(load_store_is_write), 32'(st));
                if (st) begin
                    check("store_strobe", 32'(store_strobe), 32'(strb));
                    check("store_data", store_data, sdat);
                end
                if (i == lsd) begin
                    load_store_ready = 1'b1;
                end else begin
                    load_store_result_valid = ($urandom_range(0, 2) == 0);
                    load_data = $urandom;
                end
                @(negedge CLK);
                load_store_ready        = 1'b0;
                load_store_result_valid = 1'b0;
            end
            for (int i = 0; i <= rsd; i++) begin
                check("ls_valid_wait", 32'(load_store_valid), 32'd0);
                check("ls_addr_wait", load_store_addr, addr & 32'hFFFF_FFFC);
                if (st) begin
                    check("strobe_wait", 32'(store_strobe), 32'(strb));
                    check("data_wait", store_data, sdat);
                end
                check("resp_valid_wait", 32'(resp_valid), 32'd0);
                if (i == rsd) begin
                    load_data = rd;
                    load_store_result_valid = 1'b1;
                end else begin
                    load_data = $urandom;
                end
                @(negedge CLK);
                load_store_result_valid = 1'b0;
                load_data = $urandom;
            end
        end else begin
            check("ls_valid_err", 32'(load_store_valid), 32'd0);
        end
        for (int i = 0; i <= rrd; i++) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_data", resp_data, rdat);
            check("resp_tag", 32'(resp_tag), 32'(tag));
            check("resp_error", 32'(resp_error), 32'(err));
            check("req_ready_resp", 32'(req_ready), 32'd0);
            check("ls_valid_resp", 32'(load_store_valid), 32'd0);
            if (i == rrd) begin
                resp_ready = 1'b1;
            end else begin
                load_store_result_valid = ($urandom_range(0, 2) == 0);
                load_data = $urandom;
            end
            @(negedge CLK);
            resp_ready = 1'b0;
            load_store_result_valid = 1'b0;
        end
        check("resp_valid_done", 32'(resp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_ls_valid"}, 32'(load_store_valid), 32'd0);
        check({tag, "_ls_addr"}, load_store_addr, 32'd0);
        check({tag, "_is_write"}, 32'(load_store_is_write), 32'd0);
        check({tag, "_strobe"}, 32'(store_strobe), 32'd0);
        check({tag, "_store_data"}, store_data, 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_resp_tag"}, 32'(resp_tag), 32'd0);
        check({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        checks   = 0;
        failures = 0;
        RSTn = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_is_store = 1'b0;
        req_funct3 = '0;
        req_store_data = '0;
        req_tag = '0;
        resp_ready = 1'b0;
        load_store_ready = 1'b0;
        load_store_result_valid = 1'b0;
        load_data = '0;
        @(negedge CLK);
        check_reset_outputs("rst");
        check("result_ready", 32'(load_store_result_ready), 32'd1);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        // stray pulse while idle
        load_data = 32'h1234_5678;
        load_store_result_valid = 1'b1;
        @(negedge CLK);
        load_store_result_valid = 1'b0;
        check("stray_idle_resp_valid", 32'(resp_valid), 32'd0);
        check("stray_idle_req_ready", 32'(req_ready), 32'd1);

        do_op(1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEADBEEF, 5'd7, 0, 0, 0);
        do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 5'd3, 0, 0, 0);
        do_op(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 5'd4, 0, 0, 0);
        do_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 5'd9, 0, 0, 0);
        do_op(1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 5'd11, 0, 0, 0);
        do_op(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 5'd12, 0, 0, 0);
        do_op(1'b1, 3'b100, 32'h0000_1001, 32'h0, 32'h0, 5'd13, 0, 0, 0);
        do_op(1'b1, 3'b000, 32'h0000_3001, 32'hA5A5_A5C3, 32'h0, 5'd14, 3, 1, 2);
        do_op(1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'h8001_7FFE, 5'd15, 3, 2, 2);

        // asynchronous reset while waiting for the result
        req_valid = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h0000_4008;
        req_tag = 5'd21;
        @(negedge CLK);
        req_valid = 1'b0;
        load_store_ready = 1'b1;
        @(negedge CLK);
        load_store_ready = 1'b0;
        check("pre_rst_wait_ls_valid", 32'(load_store_valid), 32'd0);
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge CLK);
        RSTn = 1'b1;
        load_store_result_valid = 1'b1;
        load_data = 32'hCAFE_F00D;
        @(negedge CLK);
        load_store_result_valid = 1'b0;
        check("post_rst_stray_resp", 32'(resp_valid), 32'd0);
        check("post_rst_stray_ready", 32'(req_ready), 32'd1);
        do_op(1'b0, 3'b010, 32'h0000_4008, 32'h0, 32'h0BAD_CAFE, 5'd22, 1, 1, 1);

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (st)
                f3 = 3'($urandom_range(0, 2));
            else
                f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
            do_op(st, f3, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
